// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request port, execute redirect/halt controls
// and the decode-side valid/ready instruction handshake.
interface fetch_stage_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned WORD_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic              imem_ren;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ready;
   logic [WORD_W-1:0] imem_rdata;
   logic              redirect;
   logic [WORD_W-1:0] redirect_pc;
   logic              halt;
   logic              instr_valid;
   logic [WORD_W-1:0] instr;
   logic [WORD_W-1:0] instr_pc;
   logic              instr_ready;
   logic [CNT_W-1:0]  fifo_count;

   modport master (
      output imem_ren, imem_addr,
      input  imem_ready, imem_rdata,
      input  redirect, redirect_pc, halt,
      output instr_valid, instr, instr_pc,
      input  instr_ready,
      output fifo_count
   );

   modport slave (
      input  imem_ren, imem_addr,
      output imem_ready, imem_rdata,
      output redirect, redirect_pc, halt,
      input  instr_valid, instr, instr_pc,
      output instr_ready,
      input  fifo_count
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem reads into a PC-tagged FIFO feeding decode,
// with redirect flush/discard and a sticky halt.
module fetch_stage #(
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       WORD_W   = 32,
   parameter logic [WORD_W-1:0] RESET_PC = '0
) (
   input logic           CLK,
   input logic           nRST,
   fetch_stage_if.master bus
);
   localparam int unsigned      PTR_W = $clog2(DEPTH);
   localparam int unsigned      CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e            r_state, w_state_next;
   logic [WORD_W-1:0] r_pc, r_addr, w_pc_next, w_redirect_pc;
   logic              r_discard, r_halted;
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [CNT_W-1:0]  r_count, w_count_next;
   logic [WORD_W-1:0] r_mem_instr [DEPTH];
   logic [WORD_W-1:0] r_mem_pc    [DEPTH];
   logic              w_resp, w_push, w_pop, w_halted, w_load_addr;
   logic              w_unused_rpc_lo;

   assign w_redirect_pc   = {bus.redirect_pc[WORD_W-1:2], 2'b00};
   assign w_unused_rpc_lo = ^bus.redirect_pc[1:0];

   assign w_resp   = (r_state == StReq) && bus.imem_ready;
   assign w_push   = w_resp && !r_discard && !bus.redirect;
   assign w_pop    = (r_count != '0) && bus.instr_ready && !bus.redirect;
   assign w_halted = r_halted || bus.halt;

   always_comb begin
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      w_pc_next    = w_push ? r_pc + WORD_W'(4) : r_pc;
      if (bus.redirect) begin
         w_count_next = '0;
         w_pc_next    = w_redirect_pc;
      end
   end

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   // Next state: re-issue only while a slot is still free after this cycle's push/pop
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (!w_halted && !bus.redirect && (r_count < FULL)) w_state_next = StReq;
         StReq: begin
            if (bus.imem_ready) begin
               w_state_next = (!w_halted && (w_count_next < FULL)) ? StReq : StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      bus.imem_ren    = (r_state == StReq);
      bus.imem_addr   = r_addr;
      bus.instr_valid = (r_count != '0);
      bus.instr       = r_mem_instr[r_rptr];
      bus.instr_pc    = r_mem_pc[r_rptr];
      bus.fifo_count  = r_count;
   end

   // The request address only moves when a new request starts, never mid-request
   assign w_load_addr = (w_state_next == StReq) && ((r_state == StIdle) || bus.imem_ready);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_pc      <= RESET_PC;
         r_addr    <= RESET_PC;
         r_discard <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         r_pc <= w_pc_next;
         if (w_load_addr) r_addr <= w_pc_next;
         if (w_resp) r_discard <= 1'b0;
         else if ((r_state == StReq) && bus.redirect) r_discard <= 1'b1;
         if (bus.halt) r_halted <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem_instr[i] <= '0;
            r_mem_pc[i]    <= '0;
         end
      end else begin
         r_count <= w_count_next;
         if (bus.redirect) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            r_wptr <= r_wptr + PTR_W'(w_push);
            r_rptr <= r_rptr + PTR_W'(w_pop);
         end
         if (w_push) begin
            r_mem_instr[r_wptr] <= bus.imem_rdata;
            r_mem_pc[r_wptr]    <= r_addr;
         end
      end
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end stage directly upstream of decode (control unit) in the tensor-core pipeline.
- Generates PCs and issues single-outstanding word reads to instruction memory.
- Buffers returned instructions, tagged with their PC, in a small FIFO.
- Presents them to decode with a valid/ready handshake; supports branch/jump redirect with flush, plus a sticky halt.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, >=2).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- WORD_W, 32, instruction/address width.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imem_ren  output  1  instruction read request.
- imem_addr  output  WORD_W  byte address of request.
- imem_ready  input  1  request accepted and imem_rdata valid this cycle.
- imem_rdata  input  WORD_W  returned instruction word.
- redirect  input  1  taken branch/jal/jalr from execute; flush and refetch.
- redirect_pc  input  WORD_W  new fetch target, valid with redirect.
- halt  input  1  halt decoded; stop fetching.
- instr_valid  output  1  FIFO head valid.
- instr  output  WORD_W  FIFO head instruction.
- instr_pc  output  WORD_W  PC of FIFO head.
- instr_ready  input  1  decode accepts head this cycle.
- fifo_count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, nRST=0):
  - pc=RESET_PC, state=IDLE, FIFO empty, discard=0, halted=0.
  - Outputs: imem_ren=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fifo_count=0.
  - Reset mid-request abandons it; the memory must tolerate a dropped ren.
- State machine IDLE / REQ:
  - IDLE -> REQ when !halted && !redirect && fifo_count < DEPTH. Set imem_ren=1, imem_addr=pc.
  - REQ: imem_ren and imem_addr held stable until imem_ready; never change mid-request.
  - REQ on imem_ready:
    - If !discard && !redirect: push {imem_rdata, pc} into FIFO, pc <= pc+4.
    - Then -> REQ again (back-to-back, no bubble) if fifo_count-after-update < DEPTH && !halted; else -> IDLE.
  - Throughput: one instruction per imem_ready cycle when memory is zero-wait.
- Slot reservation: a request is issued only if a FIFO slot is free counting the outstanding request, so a push never meets a full FIFO.
- FIFO:
  - Pop when instr_valid && instr_ready. Head fields (instr_valid, instr, instr_pc) driven from registered storage.
  - Simultaneous push and pop: count unchanged, both occur.
  - Pointers wrap modulo DEPTH.
  - instr/instr_pc hold last value when empty (don't-care, not required zero).
- Redirect (single-cycle pulse, highest priority):
  - Flush FIFO (count=0 next cycle); pc <= redirect_pc.
  - Any pop in the redirect cycle is void; decode also flushes.
  - In IDLE: next cycle goes REQ at redirect_pc if not halted.
  - In REQ without imem_ready: set discard=1 and keep request stable. On its imem_ready, drop the data and clear discard. Next request uses redirect_pc.
  - Redirect in the same cycle as imem_ready: response dropped, discard not set. Next cycle REQ at redirect_pc.
  - Second redirect while discard=1: pc updates to the newest target; discard stays 1.
  - redirect_pc[1:0] assumed 0; low bits are forced to 0.
- Halt:
  - halt=1 sets sticky halted; cleared only by reset.
  - An in-flight request completes and is enqueued; no new requests issue.
  - FIFO continues draining to decode.
  - A redirect while halted updates pc and flushes, but no fetch issues.
- pc arithmetic: WORD_W-bit, wraps 32'hFFFF_FFFC -> 0.

Test Plan:
- Reset, zero-wait imem, instr_ready=1 -> imem_addr 0,4,8,12 on consecutive cycles; instr_pc follows 1 cycle after each response; fifo_count stays <=1.
- instr_ready=0, zero-wait imem -> exactly 4 pushes (addrs 0..12); imem_ren drops at count 4. One pop -> next request at addr 16.
- imem_ready delayed 3 cycles at addr 8, redirect to 0x100 on wait cycle 1 -> addr 8 held to completion; its data not enqueued; next imem_addr=0x100; FIFO count 0 after flush.
- Redirect to 0x40 coinciding with imem_ready and a pop -> no push, pop void, count 0; next cycle imem_addr=0x40.
- halt during request at addr 20 -> word at 20 enqueued; no further imem_ren; FIFO drains; later redirect to 0x80 -> still no imem_ren.
- Assert nRST low while in REQ with 2 entries buffered -> outputs immediately at reset values; after release, first imem_addr=RESET_PC.
